bcd_calc_sequencer: RTL
=======================

# bcd_calc_sequencer

Sequencing controller for the lab calculator datapath. It sits between the switch/operation decode stage and the 7-segment display driver. On a start request it captures one BCD operand pair and an operation code, then runs the operation over one or more clock cycles: single-cycle BCD add or subtract, or multiply by repeated BCD addition. It presents a registered two-digit BCD result with sign, error, busy and done status.

## Interface

Parameters:
- OP_ADD, 3'b010, operation code for addition
- OP_SUB, 3'b100, operation code for subtraction
- OP_MUL, 3'b111, operation code for multiplication

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- start  input  1  level request from a debounced button; only a rising edge is acted on
- num1_bcd  input  4  operand A, one BCD digit
- num2_bcd  input  4  operand B, one BCD digit
- operation  input  3  operation code
- result_bcd  output  8  result: [7:4] tens digit, [3:0] ones digit
- neg  output  1  result is negative (subtraction only)
- err  output  1  last request was invalid
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when a new result is loaded

## Operation

- States are IDLE, EXEC and DONE.
- Start edge detection:
  - A start_q register holds the previous value of start.
  - An edge is start=1 and start_q=0.
  - start_q resets to 1, so a button held through reset does not fire.
- IDLE:
  - On an edge, latch A, B and the op code into internal registers.
  - Clear the accumulator to 0x00, load cnt with B, and go to EXEC.
  - Without an edge, stay in IDLE. busy=0.
- EXEC, error check:
  - If the latched A>9, B>9, or the op is not one of the three codes:
    - result_bcd=0x00, neg=0, err=1, done=1.
    - Go to DONE.
- EXEC, add:
  - The sum A+B (0..18) is BCD-adjusted: sum>9 gives tens=1 and ones=sum-10.
  - Load result, neg=0, err=0, done=1, go to DONE.
- EXEC, subtract:
  - If A>=B: ones=A-B, neg=0.
  - Otherwise: ones=B-A, neg=1.
  - tens=0, err=0, done=1, go to DONE.
- EXEC, multiply:
  - If cnt≠0: acc = acc + A in BCD, cnt = cnt-1, stay in EXEC.
    - BCD add: add A to the ones digit; if the ones digit exceeds 9, subtract 10 and increment tens.
  - If cnt=0: result_bcd=acc, neg=0, err=0, done=1, go to DONE.
  - Maximum result is 0x81. Tens never exceeds 8, so there is no overflow.
- DONE:
  - done is cleared, and the state returns to IDLE unconditionally.
  - A start edge seen in this cycle is ignored.
- Start edges while busy=1 are ignored. Operand or op changes after the latch have no effect.
- result_bcd, neg and err hold their value until the next done.
- Reset at any time, including mid-multiply:
  - state=IDLE, result_bcd=0x00, neg=0, err=0, busy=0, done=0, acc=0, cnt=0, start_q=1.
  - No done pulse is produced for the aborted operation.

## Timing

- Reset values of all outputs: result_bcd=0x00, neg=0, err=0, busy=0, done=0.
- Let edge k be the clock edge that samples the start edge in IDLE.
- busy rises after edge k.
- Add, subtract and error cases: result is loaded and done rises after edge k+1. done falls and busy falls after edge k+2.
- Multiply with operand B: result is loaded and done rises after edge k+B+1. busy falls after edge k+B+2.
  - B=0 completes like an add: done after edge k+1, result 0x00.
- done is exactly one cycle wide. busy covers EXEC and DONE.
- Earliest next accepted request: a start edge sampled at edge k+3 for add/subtract, provided start was seen low at or after edge k+2.
- Outputs are fully registered, with no combinational path from inputs.

## Test plan

- Add: reset, then A=7, B=8, op=3'b010, start pulse. Required: done one cycle after edge k+1, result_bcd=0x15, neg=0, err=0.
- Subtract: A=3, B=9, op=3'b100. Required: result_bcd=0x06, neg=1. Then A=9, B=3 gives 0x06, neg=0.
- Multiply: A=9, B=9, op=3'b111. Required: busy for 11 cycles, done after edge k+10, result_bcd=0x81. Also A=5, B=0 gives 0x00 with done after edge k+1.
- Errors: op=3'b000 gives err=1, result 0x00. A=4'hC with op=add gives err=1. The next valid add clears err.
- Ignored starts: pulse start again mid-multiply and in the DONE cycle. Required: exactly one done and an unchanged result. Also hold start high through reset release; no operation may start until start has been low and then high again.
- Reset mid-operation: assert rst_n=0 mid-multiply. Required: immediate outputs 0x00/0/0/0/0 and no done. The next request completes normally.

Source files
------------

// File: rtl/bcd_calc_sequencer.sv
// Sequencing controller for the lab calculator: captures one BCD operand pair on a start edge,
// runs add/subtract in one cycle or multiply by repeated BCD addition, and presents registered status.
module bcd_calc_sequencer #(
    parameter logic [2:0] OP_ADD = 3'b010,
    parameter logic [2:0] OP_SUB = 3'b100,
    parameter logic [2:0] OP_MUL = 3'b111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] num1_bcd,
    input  logic [3:0] num2_bcd,
    input  logic [2:0] operation,
    output logic [7:0] result_bcd,
    output logic       neg,
    output logic       err,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       start_q;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [2:0] op_q, op_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic       neg_q, neg_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       start_edge;
    logic       req_invalid;
    logic [4:0] add_sum;
    logic [7:0] add_bcd;
    logic [3:0] sub_mag;
    logic [4:0] mul_ones_sum;
    logic [7:0] mul_step;

    assign start_edge  = start & ~start_q;
    assign req_invalid = (a_q > 4'd9) || (b_q > 4'd9) ||
                         !((op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL));

    // Datapath helpers: single-digit BCD sum, subtract magnitude, and one multiply step.
    always_comb begin
        add_sum = {1'b0, a_q} + {1'b0, b_q};
        if (add_sum > 5'd9) begin
            add_bcd = {4'd1, add_sum[3:0] - 4'd10};
        end else begin
            add_bcd = {4'd0, add_sum[3:0]};
        end

        sub_mag = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);

        mul_ones_sum = {1'b0, acc_q[3:0]} + {1'b0, a_q};
        if (mul_ones_sum > 5'd9) begin
            mul_step = {acc_q[7:4] + 4'd1, mul_ones_sum[3:0] - 4'd10};
        end else begin
            mul_step = {acc_q[7:4], mul_ones_sum[3:0]};
        end
    end

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        neg_d    = neg_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    a_d     = num1_bcd;
                    b_d     = num2_bcd;
                    op_d    = operation;
                    acc_d   = 8'h00;
                    cnt_d   = num2_bcd;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (req_invalid) begin
                    result_d = 8'h00;
                    neg_d    = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (op_q == OP_ADD) begin
                    result_d = add_bcd;
                    neg_d    = 1'b0;
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (op_q == OP_SUB) begin
                    result_d = {4'd0, sub_mag};
                    neg_d    = (a_q < b_q);
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (cnt_q != 4'd0) begin
                    // Multiply: one BCD accumulation of A per remaining count of B.
                    acc_d = mul_step;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d = acc_q;
                    neg_d    = 1'b0;
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b1;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            op_q     <= 3'd0;
            acc_q    <= 8'h00;
            cnt_q    <= 4'd0;
            result_q <= 8'h00;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result_bcd = result_q;
    assign neg        = neg_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
